instr_fetch_mem: RTL
====================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DEPTH_BYTES, default 64: memory size in bytes; SHALL be a multiple of 4, range 8..4096.
REQ-002 Parameter LATENCY, default 1: cycles from fetch accept to rsp_valid; SHALL be in the range 1..4.
REQ-003 Parameter NOP_INST, default 32'h00000013: instruction returned on a faulted fetch.
REQ-004 Port: clk  in  1  sole clock; all logic on the rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: load_en  in  1  program-load byte write strobe.
REQ-007 Port: load_addr  in  32  byte address for the load write.
REQ-008 Port: load_data  in  8  byte to write.
REQ-009 Port: fetch_req  in  1  fetch request.
REQ-010 Port: fetch_addr  in  32  byte address of the instruction (PC).
REQ-011 Port: fetch_ack  out  1  request accepted this cycle; combinational.
REQ-012 Port: rsp_valid  out  1  response valid.
REQ-013 Port: rsp_ready  in  1  consumer accepts the response.
REQ-014 Port: rsp_inst  out  32  fetched instruction word.
REQ-015 Port: rsp_fault  out  2  00 = ok, 01 = misaligned, 10 = out of range.
REQ-016 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-017 Storage SHALL be DEPTH_BYTES x 8 bits, little-endian: word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
REQ-018 When load_en=1 and load_addr < DEPTH_BYTES, mem[load_addr] SHALL be written with load_data at the clock edge; an out-of-range load SHALL be ignored silently.
REQ-019 fetch_ack SHALL equal fetch_req & (state==IDLE) & ~load_en; a load always blocks acceptance.
REQ-020 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-021 IDLE->WAIT on fetch_ack when LATENCY>1, with the countdown loaded to LATENCY-1; IDLE->RESP on fetch_ack when LATENCY=1.
REQ-022 WAIT SHALL decrement the countdown each cycle and move to RESP on the cycle the countdown reaches 1.
REQ-023 RESP: rsp_valid=1; on rsp_valid & rsp_ready the FSM SHALL return to IDLE; there is no back-to-back acceptance, so the next fetch_ack is possible in the following cycle at the earliest.
REQ-024 Accept at edge N SHALL give rsp_valid=1 from cycle N+LATENCY.
REQ-025 The word and fault SHALL be captured at the accept edge; later loads SHALL NOT alter a response already in flight.
REQ-026 rsp_inst, rsp_fault and rsp_valid SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Fault priority:
  - fetch_addr[1:0] != 0 -> 01.
  - otherwise, fetch_addr > DEPTH_BYTES-4 -> 10.
  - otherwise -> 00.
REQ-028 On any fault, rsp_inst SHALL be NOP_INST.
REQ-029 Address arithmetic SHALL use the full 32-bit fetch_addr compared without truncation, so high addresses never alias into memory.
REQ-030 rsp_inst and rsp_fault SHALL be registered outputs.

Reset
REQ-031 With reset=1 at a rising edge, the following SHALL apply at that edge:
  - state -> IDLE and countdown -> 0;
  - rsp_valid=0, rsp_inst=32'h0, rsp_fault=2'b00, busy=0;
  - any in-flight fetch is discarded.
REQ-032 Reset SHALL NOT modify memory contents; a loaded program survives reset.
REQ-033 While reset=1, fetch_ack SHALL be 0 and load writes SHALL be ignored.
REQ-034 Reset has priority over all other inputs in the same cycle.

Verification
REQ-035 Load program: load bytes 03,a3,02,00 at addresses 0..3; fetch 0 with LATENCY=1 and rsp_ready=1 -> rsp_valid=1 one cycle after accept, rsp_inst=32'h0002a303, rsp_fault=00.
REQ-036 Backpressure: LATENCY=3, fetch 4 (word 32'h00428293), rsp_ready=0 for 5 cycles -> rsp_valid rises 3 cycles after accept; the word holds 5 cycles; fetch_ack stays 0 throughout.
REQ-037 Faults with DEPTH_BYTES=64:
  - fetch 6 -> fault 01, rsp_inst 32'h00000013;
  - fetch 64 -> fault 10;
  - fetch 32'hFFFF_FFFC -> fault 10;
  - fetch 60 -> fault 00.
REQ-038 Load/fetch collision: load_en=1 and fetch_req=1 in the same cycle -> fetch_ack=0 and the byte is written; fetch accepted next cycle returns the new data. A load to the same word during WAIT -> the response returns the old word.
REQ-039 Reset mid-operation:
  - reset during WAIT -> rsp_valid=0 next cycle, busy=0, and the previously loaded word is still readable;
  - reset during RESP with rsp_ready=0 -> response dropped.
REQ-040 Load range: load_addr=64 with DEPTH_BYTES=64 -> no write, verified by reading back all 64 bytes unchanged.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: byte-loadable program store with a single
// outstanding fetch, fixed response latency and ready/valid backpressure.
// Storage is split into four byte lanes so an aligned word read touches one
// entry per lane; the fetched word and its fault code are captured into the
// output registers on the accept edge.
module instr_fetch_mem #(
  parameter int          DEPTH_BYTES = 64,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic [1:0]  rsp_fault,
  output logic        busy
);

  localparam int          WORDS          = DEPTH_BYTES / 4;
  localparam int          IDX_W          = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] DEPTH_W        = 32'(DEPTH_BYTES);
  localparam logic [31:0] LAST_WORD_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [1:0]  CNT_INIT       = 2'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       cnt_reg;
  logic [1:0]       cnt_next;

  logic             load_hit;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic [31:0]      fetch_word;
  logic [1:0]       fetch_fault;

  // Full 32-bit compare so high load addresses never wrap into memory;
  // loads are also blocked while reset is held.
  assign load_hit  = ~reset & load_en & (load_addr < DEPTH_W);
  assign load_idx  = load_addr[IDX_W+1:2];
  assign fetch_idx = fetch_addr[IDX_W+1:2];

  // A load in the same cycle always wins over a fetch, so the lane RAMs never
  // see a read and a write in the same cycle.
  assign fetch_ack = fetch_req & (state_reg == IDLE) & ~load_en & ~reset;

  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      // Byte lane gi holds every byte whose address ends in gi.
      always_ff @(posedge clk) begin
        if (load_hit && (load_addr[1:0] == 2'(gi))) begin
          lane_mem[load_idx] <= load_data;
        end
      end

      // Little-endian assembly: lane 0 is the least significant byte.
      assign fetch_word[gi*8 +: 8] = lane_mem[fetch_idx];
    end
  endgenerate

  // Misalignment outranks range; range uses the untruncated address.
  always_comb begin
    fetch_fault = 2'b00;
    if (fetch_addr[1:0] != 2'b00) begin
      fetch_fault = 2'b01;
    end else if (fetch_addr > LAST_WORD_ADDR) begin
      fetch_fault = 2'b10;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, hold in RESP until taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (fetch_ack) begin
          if (LATENCY > 1) begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // State and countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Response registers: loaded only on accept, so they hold through WAIT and
  // RESP regardless of later loads or backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_inst  <= 32'h0;
      rsp_fault <= 2'b00;
    end else if (fetch_ack) begin
      rsp_fault <= fetch_fault;
      rsp_inst  <= (fetch_fault != 2'b00) ? NOP_INST : fetch_word;
    end
  end

endmodule
